// File: rtl/bridge_uart_responder.sv
// UART-to-bus bridge responder: parses A5/CMD/ADDR_H/ADDR_L[/DATA] request frames,
// runs one bus transaction, and answers with 0x5A followed by read data or 0x00.
module bridge_uart_responder #(
   parameter int unsigned ADDR_W      = 16,
   parameter int unsigned TIMEOUT_CYC = 1000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        rx_byte,
   input  logic              rx_valid,
   output logic [7:0]        tx_byte,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic              bus_req,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [7:0]        bus_wdata,
   input  logic              bus_ack,
   input  logic [7:0]        bus_rdata,
   output logic [7:0]        err_cnt
);

   localparam int unsigned GAP_W   = 16;
   localparam logic [7:0]  SYNC    = 8'hA5;
   localparam logic [7:0]  ACK_TOK = 8'h5A;

   typedef enum logic [2:0] {
      S_IDLE, S_CMD, S_ADDR_H, S_ADDR_L, S_DATA, S_BUS, S_RESP0, S_RESP1
   } state_t;

   state_t             state_q, state_d;
   logic [GAP_W-1:0]   gap_q, gap_d;
   logic               we_q, we_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [7:0]         wdata_q, wdata_d;
   logic [7:0]         rdata_q, rdata_d;
   logic [7:0]         tx_byte_q, tx_byte_d;
   logic               tx_valid_q, tx_valid_d;
   logic               bus_req_q, bus_req_d;
   logic [7:0]         err_q, err_d;
   logic               err_ev;
   logic               in_frame;

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         gap_q      <= '0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         tx_byte_q  <= '0;
         tx_valid_q <= 1'b0;
         bus_req_q  <= 1'b0;
         err_q      <= '0;
      end else begin
         state_q    <= state_d;
         gap_q      <= gap_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         rdata_q    <= rdata_d;
         tx_byte_q  <= tx_byte_d;
         tx_valid_q <= tx_valid_d;
         bus_req_q  <= bus_req_d;
         err_q      <= err_d;
      end
   end

   // Next-state, datapath and error accounting
   always_comb begin
      state_d    = state_q;
      gap_d      = '0;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      tx_byte_d  = tx_byte_q;
      tx_valid_d = tx_valid_q;
      bus_req_d  = bus_req_q;
      err_d      = err_q;
      err_ev     = 1'b0;
      in_frame   = (state_q == S_CMD) || (state_q == S_ADDR_H) ||
                   (state_q == S_ADDR_L) || (state_q == S_DATA);

      // Inter-byte gap only matters while a request frame is being collected
      if (in_frame) begin
         if (rx_valid) begin
            gap_d = '0;
         end else if (gap_q == GAP_W'(TIMEOUT_CYC - 1)) begin
            state_d = S_IDLE;
            err_ev  = 1'b1;
         end else begin
            gap_d = gap_q + GAP_W'(1);
         end
      end

      case (state_q)
         S_IDLE: begin
            if (rx_valid && rx_byte == SYNC) state_d = S_CMD;
         end
         S_CMD: begin
            if (rx_valid) begin
               if (rx_byte[7:1] == 7'd0) begin
                  we_d    = rx_byte[0];
                  state_d = S_ADDR_H;
               end else begin
                  state_d = S_IDLE;
                  err_ev  = 1'b1;
               end
            end
         end
         S_ADDR_H: begin
            if (rx_valid) begin
               addr_d[ADDR_W-1 -: 8] = rx_byte;
               state_d = S_ADDR_L;
            end
         end
         S_ADDR_L: begin
            if (rx_valid) begin
               addr_d[7:0] = rx_byte;
               state_d     = we_q ? S_DATA : S_BUS;
               bus_req_d   = !we_q;
            end
         end
         S_DATA: begin
            if (rx_valid) begin
               wdata_d   = rx_byte;
               state_d   = S_BUS;
               bus_req_d = 1'b1;
            end
         end
         S_BUS: begin
            if (bus_ack) begin
               rdata_d    = bus_rdata;
               bus_req_d  = 1'b0;
               tx_byte_d  = ACK_TOK;
               tx_valid_d = 1'b1;
               state_d    = S_RESP0;
            end
         end
         S_RESP0: begin
            if (tx_ready) begin
               tx_byte_d = we_q ? 8'h00 : rdata_q;
               state_d   = S_RESP1;
            end
         end
         S_RESP1: begin
            if (tx_ready) begin
               tx_valid_d = 1'b0;
               state_d    = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Bytes arriving while the bridge is busy are lost
      if (rx_valid && (state_q == S_BUS || state_q == S_RESP0 || state_q == S_RESP1))
         err_ev = 1'b1;

      if (err_ev && err_q != 8'hFF) err_d = err_q + 8'd1;
   end

   assign tx_byte   = tx_byte_q;
   assign tx_valid  = tx_valid_q;
   assign bus_req   = bus_req_q;
   assign bus_we    = we_q;
   assign bus_addr  = addr_q;
   assign bus_wdata = wdata_q;
   assign err_cnt   = err_q;

endmodule

// File: doc/bridge_uart_responder.md
BRIDGE_UART_RESPONDER -- requirements
Module: bridge_uart_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, bus address width; fixed at 16 (two address bytes).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1000, maximum idle cycles between request bytes.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port rx_byte  input  8  received UART byte.
REQ-006 SHALL have port rx_valid  input  1  one-cycle strobe, rx_byte valid.
REQ-007 SHALL have port tx_byte  output  8  response byte to UART transmitter.
REQ-008 SHALL have port tx_valid  output  1  tx_byte valid, held until accepted.
REQ-009 SHALL have port tx_ready  input  1  transmitter accepts byte when tx_valid&&tx_ready.
REQ-010 SHALL have port bus_req  output  1  bus transaction request, held until bus_ack.
REQ-011 SHALL have port bus_we  output  1  1 = write, 0 = read.
REQ-012 SHALL have port bus_addr  output  ADDR_W  transaction address.
REQ-013 SHALL have port bus_wdata  output  8  write data.
REQ-014 SHALL have port bus_ack  input  1  one-cycle completion strobe from bus.
REQ-015 SHALL have port bus_rdata  input  8  read data, valid with bus_ack.
REQ-016 SHALL have port err_cnt  output  8  saturating protocol-error count.

Function
REQ-017 SHALL parse request frame: SYNC 0xA5, CMD, ADDR_H, ADDR_L, then DATA only if CMD=0x01 (write); CMD=0x00 is read.
REQ-018 SHALL use states IDLE, CMD, ADDR_H, ADDR_L, DATA, BUS, RESP0, RESP1.
REQ-019 IDLE: rx_valid with 0xA5 -> CMD; any other byte discarded, no error counted.
REQ-020 CMD: 0x00/0x01 latched as bus_we -> ADDR_H; any other value -> IDLE, err_cnt+1.
REQ-021 ADDR_H/ADDR_L latch bus_addr[15:8]/[7:0]; after ADDR_L: write -> DATA, read -> BUS.
REQ-022 DATA latches bus_wdata -> BUS.
REQ-023 BUS: bus_req=1 from the cycle after the final request byte until and including the bus_ack cycle; bus_addr/bus_we/bus_wdata stable throughout.
REQ-024 On bus_ack: capture bus_rdata (read) -> RESP0; bus_req low the next cycle.
REQ-025 RESP0: tx_byte=0x5A, tx_valid=1; on tx_ready -> RESP1.
REQ-026 RESP1: tx_byte=captured rdata (read) or 0x00 (write), tx_valid=1; on tx_ready -> IDLE.
REQ-027 tx_byte SHALL not change while tx_valid=1 and tx_ready=0.
REQ-028 Bus latency unbounded; no timeout in BUS/RESP states.
REQ-029 In CMD..DATA, a 16-bit gap counter SHALL clear on each rx_valid and increment otherwise; reaching TIMEOUT_CYC -> IDLE, err_cnt+1.
REQ-030 rx_valid in BUS, RESP0 or RESP1 SHALL be dropped and increment err_cnt (overrun).
REQ-031 err_cnt SHALL saturate at 0xFF; multiple error events in one cycle count once.
REQ-032 bus_ack outside BUS SHALL be ignored.

Reset
REQ-033 rst_n=0 SHALL immediately force IDLE, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, tx_valid=0, tx_byte=0, err_cnt=0, gap counter 0.
REQ-034 Reset mid-frame or mid-transaction SHALL abandon it; no bus_req or tx_valid until a new complete frame.

Verification
REQ-035 Write: bytes A5 01 12 34 CD -> bus_req=1, bus_we=1, bus_addr=0x1234, bus_wdata=0xCD; ack after 3 cycles -> tx 0x5A then 0x00.
REQ-036 Read: A5 00 00 10, bus_rdata=0x77 with bus_ack -> tx 0x5A then 0x77; tx_ready low 5 cycles keeps tx_byte=0x5A stable.
REQ-037 Bad CMD: A5 07 -> IDLE, err_cnt=1, no bus_req; following valid frame processes normally.
REQ-038 Timeout: A5 01 then no byte for TIMEOUT_CYC cycles -> IDLE, err_cnt=1; garbage 0x33 then a valid frame -> err_cnt unchanged, frame served.
REQ-039 Overrun/saturation: rx_valid during BUS -> err_cnt+1, transaction completes; 300 bad-CMD frames -> err_cnt=0xFF.
REQ-040 Reset: rst_n low while bus_req=1 -> bus_req=0, tx_valid=0, err_cnt=0 without clock edge.
